// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Sequencer owning the single port of the instruction memory (DEPTH x DATA_W).
// A program streamed in by the host is written to consecutive addresses from
// 0. On start the program is fetched in order (or along jumps requested by the
// execution engine) and each opcode is offered over a valid/ready handshake.
//
// The memory is assumed to register its read data: the address presented
// during FETCH is captured by the memory at the end of FETCH, so the opcode is
// visible on mem_rdata during WAIT and is taken into instr_data on WAIT->ISSUE.
// In cycles: start seen in cycle 0, FETCH in cycle 1, WAIT in cycle 2,
// instr_valid high from cycle 3. Each handshake restarts the same
// 3-cycle FETCH/WAIT/ISSUE sequence.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   load_valid/load_data/load_last/load_ready
//                     host program stream (load_ready registered)
//   start             request to run the loaded program from address 0
//   instr_valid/instr_data/instr_addr/instr_ready
//                     opcode offer to the execution engine
//   jump_valid/jump_addr
//                     redirect of the next fetch, sampled with the handshake
//   mem_addr/mem_we/mem_wdata/mem_rdata
//                     instruction memory port
//   busy, done, err   status; err is a single-cycle pulse
//
// All outputs are registered; every output register is loaded from the
// value computed for the next state.
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Program length needs to represent DEPTH itself, one more than the
  // largest address. Comparisons between addresses and lengths are done in a
  // width wide enough for both so neither side is truncated.
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int CMP_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LEN_W-1:0]  prog_len_q, prog_len_d;

  logic              load_ready_d;
  logic              instr_valid_d;
  logic [DATA_W-1:0] instr_data_d;
  logic [ADDR_W-1:0] instr_addr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;

  logic              load_acc;
  logic [ADDR_W-1:0] load_ptr;
  logic              load_full;
  logic              load_end;
  logic              jump_ok;
  logic              pc_is_last;

  // load_ready is only ever high in IDLE/LOAD/DONE, so an accept implies one
  // of those states.
  assign load_acc  = load_valid & load_ready;

  // A word accepted outside LOAD begins a new program at address 0.
  assign load_ptr  = (state_q == S_LOAD) ? wr_ptr_q : '0;
  assign load_full = (load_ptr == ADDR_W'(DEPTH - 1));
  assign load_end  = load_last | load_full;

  assign jump_ok    = (CMP_W'(jump_addr) < CMP_W'(prog_len_q));
  assign pc_is_last = ((CMP_W'(pc_q) + CMP_W'(1)) == CMP_W'(prog_len_q));

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    prog_len_d    = prog_len_q;
    instr_valid_d = instr_valid;
    instr_data_d  = instr_data;
    instr_addr_d  = instr_addr;
    mem_addr_d    = mem_addr;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata;
    err_d         = 1'b0;

    unique case (state_q)
      S_IDLE, S_LOAD, S_DONE: begin
        if (load_acc) begin
          // Load has priority over a coincident start.
          mem_addr_d  = load_ptr;
          mem_we_d    = 1'b1;
          mem_wdata_d = load_data;
          wr_ptr_d    = load_ptr + ADDR_W'(1);
          if (load_end) begin
            state_d    = S_IDLE;
            prog_len_d = LEN_W'(CMP_W'(load_ptr) + CMP_W'(1));
          end else begin
            state_d = S_LOAD;
          end
        end else if (start && (state_q != S_LOAD)) begin
          if (prog_len_q != '0) begin
            pc_d       = '0;
            mem_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Address is already on mem_addr; memory captures it this cycle.
      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        state_d       = S_ISSUE;
        instr_valid_d = 1'b1;
        instr_data_d  = mem_rdata;
        instr_addr_d  = pc_q;
      end

      // Offer is held untouched until the engine takes it. The next fetch
      // address goes straight onto mem_addr so FETCH needs no extra cycle.
      S_ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (jump_valid) begin
            if (jump_ok) begin
              pc_d       = jump_addr;
              mem_addr_d = jump_addr;
              state_d    = S_FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end else if (pc_is_last) begin
            state_d = S_DONE;
          end else begin
            pc_d       = pc_q + ADDR_W'(1);
            mem_addr_d = pc_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // After the DEPTH-th word the host is held off for one cycle so a
    // back-to-back word is not mistaken for the start of a new program.
    load_ready_d = (state_d inside {S_IDLE, S_LOAD, S_DONE}) &&
                   !(load_acc && load_full);
    busy_d       = (state_d inside {S_LOAD, S_FETCH, S_WAIT, S_ISSUE});
    done_d       = (state_d == S_DONE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pc_q        <= '0;
      prog_len_q  <= '0;
      load_ready  <= 1'b0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_addr  <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_q        <= pc_d;
      prog_len_q  <= prog_len_d;
      load_ready  <= load_ready_d;
      instr_valid <= instr_valid_d;
      instr_data  <= instr_data_d;
      instr_addr  <= instr_addr_d;
      mem_addr    <= mem_addr_d;
      mem_we      <= mem_we_d;
      mem_wdata   <= mem_wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;

  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 26;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              start;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              err;

  int n_vec = 0;
  int n_bad = 0;

  // Reference program: what the host sent, and its length.
  logic [DATA_W-1:0] prog [DEPTH];
  int                prog_len = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
  );

  // Instruction memory: synchronous write, registered read.
  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 ns");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    start       = 1'b0;
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({load_ready, instr_valid, instr_data, instr_addr, mem_addr, mem_we,
         mem_wdata, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got lr=%b iv=%b id=%h ia=%h ma=%h we=%b wd=%h busy=%b done=%b err=%b, expected all 0",
               load_ready, instr_valid, instr_data, instr_addr, mem_addr, mem_we,
               mem_wdata, busy, done, err);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({load_ready, busy, done, err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_idle: got lr/busy/done/err=%b, expected 1000",
               {load_ready, busy, done, err});
    end
    prog_len = 0;
  endtask

  task automatic test_start_empty();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({err, busy, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL start_empty: got err/busy/done=%b, expected 100", {err, busy, done});
    end
    tick();
    n_vec++;
    if ({err, busy, load_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL start_empty_after: got err/busy/lr=%b, expected 001", {err, busy, load_ready});
    end
  endtask

  // Streams len words; directed=1 sends 1,2,3,... instead of random data.
  task automatic load_prog(input int len, input bit use_last, input bit directed);
    logic [DATA_W-1:0] w;
    bit ended;
    for (int i = 0; i < len; i++) begin
      w = directed ? DATA_W'(i + 1) : DATA_W'($urandom);
      load_valid = 1'b1;
      load_data  = w;
      load_last  = use_last && (i == len - 1);
      start      = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      n_vec++;
      if (load_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL load_ready_word%0d: got %b, expected 1", i, load_ready);
      end
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b0;
      ended      = (i == len - 1);
      n_vec++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ADDR_W'(i), w}) begin
        n_bad++;
        $display("FAIL load_write%0d: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                 i, mem_we, mem_addr, mem_wdata, i, w);
      end
      n_vec++;
      if ({busy, done, err} !== {!ended, 2'b00}) begin
        n_bad++;
        $display("FAIL load_status%0d: got busy/done/err=%b, expected %b00", i,
                 {busy, done, err}, !ended);
      end
      prog[i] = w;
      if (!ended && $urandom_range(0, 3) == 0) begin
        tick();
        n_vec++;
        if (mem_we !== 1'b0) begin
          n_bad++;
          $display("FAIL load_gap_we%0d: got %b, expected 0", i, mem_we);
        end
      end
    end
    n_vec++;
    if (load_ready !== (len != DEPTH)) begin
      n_bad++;
      $display("FAIL load_ready_after_end: got %b, expected %b", load_ready, len != DEPTH);
    end
    if (len == DEPTH) begin
      load_valid = 1'b1;
      load_data  = DATA_W'($urandom);
    end
    tick();
    load_valid = 1'b0;
    n_vec++;
    if ({mem_we, load_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL load_idle: got we/lr/busy=%b, expected 010", {mem_we, load_ready, busy});
    end
    prog_len = len;
  endtask

  // Runs the loaded program; force_at/force_to plant one jump at an address.
  task automatic run_prog(input int stall_pct, input int min_stall, input int max_stall,
                          input int jump_pct, input int force_at, input int force_to);
    int exp_pc, waitc, n, stalls, ja;
    bit jv, forced_used, fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({err, busy, done} !== 3'b010) begin
      n_bad++;
      $display("FAIL run_start: got err/busy/done=%b, expected 010", {err, busy, done});
    end
    exp_pc = 0; n = 0; fin = 1'b0; forced_used = 1'b0; waitc = 1;
    while (!fin) begin
      while (!instr_valid && waitc < 12) begin
        tick();
        waitc++;
      end
      n_vec++;
      if (waitc != 3) begin
        n_bad++;
        $display("FAIL fetch_latency: got %0d cycles, expected 3", waitc);
      end
      if (!instr_valid) return;
      n_vec++;
      if ({instr_addr, instr_data, busy, done} !== {ADDR_W'(exp_pc), prog[exp_pc], 2'b10}) begin
        n_bad++;
        $display("FAIL issue: got addr=%0d data=%h busy=%b done=%b, expected addr=%0d data=%h busy=1 done=0",
                 instr_addr, instr_data, busy, done, exp_pc, prog[exp_pc]);
      end
      stalls = ($urandom_range(1, 100) <= stall_pct) ? $urandom_range(min_stall, max_stall) : 0;
      for (int s = 0; s < stalls; s++) begin
        instr_ready = 1'b0;
        jump_valid  = 1'($urandom_range(0, 1));
        jump_addr   = ADDR_W'($urandom_range(0, 15));
        start       = 1'($urandom_range(0, 1));
        tick();
        n_vec++;
        if ({instr_valid, instr_addr, instr_data, mem_we, err} !==
            {1'b1, ADDR_W'(exp_pc), prog[exp_pc], 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b addr=%0d data=%h we=%b err=%b, expected v=1 addr=%0d data=%h we=0 err=0",
                   instr_valid, instr_addr, instr_data, mem_we, err, exp_pc, prog[exp_pc]);
        end
      end
      start = 1'b0;
      if (force_at == exp_pc && !forced_used) begin
        jv = 1'b1; ja = force_to; forced_used = 1'b1;
      end else begin
        jv = (n < 8) && ($urandom_range(1, 100) <= jump_pct);
        ja = $urandom_range(0, 15);
      end
      instr_ready = 1'b1;
      jump_valid  = jv;
      jump_addr   = ADDR_W'(ja);
      tick();
      instr_ready = 1'b0;
      jump_valid  = 1'b0;
      n++;
      n_vec++;
      if (jv && ja >= prog_len) begin
        fin = 1'b1;
        if ({instr_valid, err, done, busy} !== 4'b0110) begin
          n_bad++;
          $display("FAIL bad_jump: got v/err/done/busy=%b, expected 0110",
                   {instr_valid, err, done, busy});
        end
      end else if (!jv && exp_pc + 1 == prog_len) begin
        fin = 1'b1;
        if ({instr_valid, err, done, busy} !== 4'b0010) begin
          n_bad++;
          $display("FAIL prog_end: got v/err/done/busy=%b, expected 0010",
                   {instr_valid, err, done, busy});
        end
      end else begin
        exp_pc = jv ? ja : exp_pc + 1;
        if ({instr_valid, err, done, busy} !== 4'b0001) begin
          n_bad++;
          $display("FAIL next_fetch: got v/err/done/busy=%b, expected 0001",
                   {instr_valid, err, done, busy});
        end
      end
      waitc = 1;
      if (n > 64) begin
        n_vec++; n_bad++;
        $display("FAIL run_bound: got %0d instructions, expected at most 64", n);
        return;
      end
    end
    tick();
    n_vec++;
    if ({err, done, busy, load_ready, mem_we} !== 5'b01010) begin
      n_bad++;
      $display("FAIL done_state: got err/done/busy/lr/we=%b, expected 01010",
               {err, done, busy, load_ready, mem_we});
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, DEPTH);
      load_prog(len, (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
      run_prog(40, 1, 4, 30, -1, 0);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    load_prog(4, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!instr_valid && w < 8) begin
      tick();
      w++;
    end
    n_vec++;
    if (instr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_issue: got valid=%b, expected 1", instr_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({load_ready, instr_valid, instr_data, instr_addr, mem_addr, mem_we,
         mem_wdata, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got lr=%b iv=%b id=%h ia=%h ma=%h we=%b busy=%b done=%b err=%b, expected all 0",
               load_ready, instr_valid, instr_data, instr_addr, mem_addr, mem_we,
               busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prog_len = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({err, busy, done, load_ready} !== 4'b1001) begin
      n_bad++;
      $display("FAIL reset_mid_start: got err/busy/done/lr=%b, expected 1001",
               {err, busy, done, load_ready});
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_start_empty();
    load_prog(3, 1'b1, 1'b1);            // program 1,2,3
    run_prog(0, 0, 0, 0, -1, 0);         // straight run
    run_prog(100, 5, 5, 0, -1, 0);       // every instruction held 5 cycles
    run_prog(0, 0, 0, 0, 1, 0);          // jump back to 0 from 1
    run_prog(0, 0, 0, 0, 1, 7);          // out-of-range jump
    test_back_to_back();
    load_prog(DEPTH, 1'b0, 1'b0);        // full memory without load_last
    run_prog(20, 1, 3, 20, -1, 0);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
